// File: rtl/uio_ide_master_pkg.sv
// ---------------------------------------------------------------------------
// uio_ide_master_pkg
// Shared definitions for the UIO IDE mailbox initiator: command words for
// the bridge, the chip-select pattern that frames a register address, the
// tag the bridge puts on a status reply, job opcodes and FSM states.
// ---------------------------------------------------------------------------
package uio_ide_master_pkg;

    localparam int STROBE_GAP_DEF = 4;
    localparam int CLOSE_GAP_DEF  = 2;
    localparam int LEN_W_DEF      = 9;
    localparam int UIO_W          = 16;
    localparam int TMR_W          = 4;

    localparam logic [15:0] UIO_IDE_WR   = 16'h0061;
    localparam logic [15:0] UIO_IDE_RD   = 16'h0062;
    localparam logic [15:0] UIO_IDE_STAT = 16'h0063;

    localparam logic [6:0] IDE_CS_PATTERN = 7'b1111000;
    localparam logic [3:0] STAT_TAG       = 4'hE;

    typedef enum logic [1:0] {
        OP_STATUS = 2'd0,
        OP_WRITE  = 2'd1,
        OP_READ   = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPEN,
        ST_CMD,
        ST_ADDR,
        ST_PAD,
        ST_DATA,
        ST_CLOSE
    } state_e;

    // The reserved opcode behaves like a status poll, so it is folded
    // away at accept time and the FSM only ever sees three job kinds.
    function automatic op_e decodeOp(input logic [1:0] op);
        op_e result;
        case (op)
            2'd1:    result = OP_WRITE;
            2'd2:    result = OP_READ;
            default: result = OP_STATUS;
        endcase
        return result;
    endfunction

    // First word of every frame tells the bridge what kind of job follows.
    function automatic logic [15:0] cmdWord(input op_e op);
        logic [15:0] result;
        case (op)
            OP_WRITE: result = UIO_IDE_WR;
            OP_READ:  result = UIO_IDE_RD;
            default:  result = UIO_IDE_STAT;
        endcase
        return result;
    endfunction

    // Register address word: chip-select pattern, bank bit, then the
    // register number in the low nibble.
    function automatic logic [15:0] addrWord(input logic [4:0] addr);
        return {IDE_CS_PATTERN, addr[4], 4'b0000, addr[3:0]};
    endfunction

endpackage

// File: rtl/uio_ide_master_if.sv
// ---------------------------------------------------------------------------
// uio_ide_master_if
// UIO bus between the IDE mailbox initiator and the FPGA-side bridge.
//   io_uio    frame enable (master -> bridge)
//   io_strobe one-cycle word strobe (master -> bridge)
//   io_fpga   FPGA channel select, unused here (master -> bridge)
//   io_din    word presented in the strobe cycle (master -> bridge)
//   io_dout   bridge response, valid after a strobe (bridge -> master)
// ---------------------------------------------------------------------------
interface uio_ide_master_if;
    import uio_ide_master_pkg::*;

    logic             io_uio;
    logic             io_strobe;
    logic             io_fpga;
    logic [UIO_W-1:0] io_din;
    logic [UIO_W-1:0] io_dout;

    modport master (
        output io_uio,
        output io_strobe,
        output io_fpga,
        output io_din,
        input  io_dout
    );

    modport slave (
        input  io_uio,
        input  io_strobe,
        input  io_fpga,
        input  io_din,
        output io_dout
    );

endinterface

// File: rtl/uio_ide_master.sv
// ---------------------------------------------------------------------------
// uio_ide_master
// Turns controller-CPU IDE jobs (status poll, write N words, read N words)
// into framed word sequences on the UIO bus and captures returned words.
//   clk_sys, reset            clock, synchronous active-high reset
//   req_valid/ready/op/addr/len  job request handshake
//   wr_data/valid/ready       write data stream into the bridge
//   rd_data/valid/ready       read data stream out of the bridge
//   stat_req/stat_valid       ide_req snapshot from the last status job
//   busy, done                job in progress, one-cycle job-close pulse
//   uio                       UIO bus (master modport)
// ---------------------------------------------------------------------------
module uio_ide_master
    import uio_ide_master_pkg::*;
#(
    parameter int STROBE_GAP = STROBE_GAP_DEF,
    parameter int CLOSE_GAP  = CLOSE_GAP_DEF,
    parameter int LEN_W      = LEN_W_DEF
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [4:0]       req_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic [15:0]      wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [15:0]      rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [5:0]       stat_req,
    output logic             stat_valid,
    output logic             busy,
    output logic             done,
    uio_ide_master_if.master uio
);

    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
    localparam logic [TMR_W-1:0] TMR_GAP   = TMR_W'(STROBE_GAP - 1);
    localparam logic [TMR_W-1:0] TMR_CLOSE = TMR_W'(CLOSE_GAP - 1);
    localparam logic [LEN_W-1:0] CNT_ONE   = LEN_W'(1);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [4:0]       addr_q, addr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             rdCapt_q, rdCapt_d;
    logic             statCapt_q, statCapt_d;
    logic [15:0]      rdData_q, rdData_d;
    logic             rdValid_q, rdValid_d;
    logic [5:0]       statReq_q, statReq_d;
    logic             statValid_q, statValid_d;
    logic             done_q, done_d;
    logic             strobe;
    logic [15:0]      din;
    logic             wrTake;

    // State register. Reset drops straight to IDLE, which closes any open
    // frame on the next edge and throws away a word waiting in rd_data.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_STATUS;
            addr_q      <= '0;
            cnt_q       <= '0;
            tmr_q       <= '0;
            rdCapt_q    <= 1'b0;
            statCapt_q  <= 1'b0;
            rdData_q    <= '0;
            rdValid_q   <= 1'b0;
            statReq_q   <= '0;
            statValid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            tmr_q       <= tmr_d;
            rdCapt_q    <= rdCapt_d;
            statCapt_q  <= statCapt_d;
            rdData_q    <= rdData_d;
            rdValid_q   <= rdValid_d;
            statReq_q   <= statReq_d;
            statValid_q <= statValid_d;
            done_q      <= done_d;
        end
    end

    // Next-state and strobe generation. A single timer enforces the
    // strobe-to-strobe gap and also times the low phase after a job.
    // Data strobes for reads wait until the output register will be free,
    // and the frame only closes once the final read word has landed in
    // rd_data, so the bridge never overruns the consumer.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        tmr_d       = tmr_q;
        rdCapt_d    = 1'b0;
        statCapt_d  = 1'b0;
        done_d      = 1'b0;
        strobe      = 1'b0;
        din         = '0;
        wrTake      = 1'b0;
        rdData_d    = rdData_q;
        rdValid_d   = rdValid_q;
        statReq_d   = statReq_q;
        statValid_d = 1'b0;

        if (tmr_q != '0) begin
            tmr_d = tmr_q - TMR_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_OPEN;
                    op_d    = decodeOp(req_op);
                    addr_d  = req_addr;
                    cnt_d   = req_len;
                    tmr_d   = '0;
                end
            end
            ST_OPEN: begin
                state_d = ST_CMD;
            end
            ST_CMD: begin
                if (tmr_q == '0) begin
                    strobe = 1'b1;
                    din    = cmdWord(op_q);
                    if (op_q == OP_STATUS) begin
                        statCapt_d = 1'b1;
                        state_d    = ST_CLOSE;
                        tmr_d      = TMR_CLOSE;
                        done_d     = 1'b1;
                    end else begin
                        state_d = ST_ADDR;
                        tmr_d   = TMR_GAP;
                    end
                end
            end
            ST_ADDR: begin
                if (tmr_q == '0) begin
                    strobe  = 1'b1;
                    din     = addrWord(addr_q);
                    state_d = ST_PAD;
                    tmr_d   = TMR_GAP;
                end
            end
            ST_PAD: begin
                if (tmr_q == '0) begin
                    strobe  = 1'b1;
                    state_d = ST_DATA;
                    tmr_d   = TMR_GAP;
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    if (!rdCapt_q) begin
                        state_d = ST_CLOSE;
                        tmr_d   = TMR_CLOSE;
                        done_d  = 1'b1;
                    end
                end else if (tmr_q == '0) begin
                    if (op_q == OP_WRITE) begin
                        if (wr_valid) begin
                            strobe = 1'b1;
                            din    = wr_data;
                            wrTake = 1'b1;
                            cnt_d  = cnt_q - CNT_ONE;
                            tmr_d  = TMR_GAP;
                        end
                    end else if (!rdCapt_q && (!rdValid_q || rd_ready)) begin
                        strobe   = 1'b1;
                        rdCapt_d = 1'b1;
                        cnt_d    = cnt_q - CNT_ONE;
                        tmr_d    = TMR_GAP;
                    end
                end
            end
            ST_CLOSE: begin
                if (tmr_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Read word register: a fresh capture wins over a consumer accept.
        if (rdCapt_q) begin
            rdData_d  = uio.io_dout;
            rdValid_d = 1'b1;
        end else if (rdValid_q && rd_ready) begin
            rdValid_d = 1'b0;
        end

        // Status replies without the bridge tag are ignored entirely.
        if (statCapt_q && (uio.io_dout[15:12] == STAT_TAG)) begin
            statReq_d   = uio.io_dout[5:0];
            statValid_d = 1'b1;
        end
    end

    assign req_ready     = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign wr_ready      = wrTake;
    assign rd_data       = rdData_q;
    assign rd_valid      = rdValid_q;
    assign stat_req      = statReq_q;
    assign stat_valid    = statValid_q;
    assign uio.io_uio    = (state_q == ST_OPEN) || (state_q == ST_CMD) ||
                           (state_q == ST_ADDR) || (state_q == ST_PAD) ||
                           (state_q == ST_DATA);
    assign uio.io_strobe = strobe;
    assign uio.io_fpga   = 1'b0;
    assign uio.io_din    = din;

endmodule
